// File: rtl/card_select_ctrl.sv
// Memory-card game controller: cursor movement, pair selection, compare/hold, scoring.
// Optional miss counter output enabled by defining MISS_COUNT_EN.
module card_select_ctrl #(
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    input  logic [47:0] layout,
    output logic [3:0]  cursor_pos,
    output logic        cursor_en,
    output logic [15:0] face_up,
    output logic [15:0] matched,
    output logic [3:0]  score,
    output logic        busy,
    output logic        game_done
`ifdef MISS_COUNT_EN
    ,
    output logic [7:0]  misses
`endif
);

    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PICK1   = 3'd0,
        S_PICK2   = 3'd1,
        S_COMPARE = 3'd2,
        S_SHOW    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_first;
    logic [3:0]      r_second;
    logic [TW-1:0]   r_timer;

    logic [2:0]      w_sym [16];
    logic            w_dir;
    logic            w_sel;
    logic            w_pick_ok;
    logic            w_match;
    logic            w_timer_zero;
    logic            w_cursor_en_next;
    logic            w_busy_next;
    logic            w_done_next;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sym
            assign w_sym[gi] = layout[3*gi +: 3];
        end
    endgenerate

    // A direction pulse always wins over a simultaneous select.
    assign w_dir        = btn_up | btn_down | btn_left | btn_right;
    assign w_sel        = btn_sel & ~w_dir;
    assign w_pick_ok    = w_sel & ~face_up[cursor_pos];
    assign w_match      = (w_sym[r_first] == w_sym[r_second]);
    assign w_timer_zero = (r_timer == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_PICK1;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_PICK1:   if (w_pick_ok) w_state_next = S_PICK2;
            S_PICK2:   if (w_pick_ok) w_state_next = S_COMPARE;
            S_COMPARE: begin
                if (w_match) begin
                    w_state_next = (score == 4'd7) ? S_DONE : S_PICK1;
                end else begin
                    w_state_next = S_SHOW;
                end
            end
            S_SHOW:    if (w_timer_zero) w_state_next = S_PICK1;
            S_DONE:    if (w_sel) w_state_next = S_PICK1;
            default:   w_state_next = S_PICK1;
        endcase
    end

    // Status flags are registered from the next state so they line up with r_state.
    always_comb begin
        w_cursor_en_next = (w_state_next == S_PICK1) || (w_state_next == S_PICK2);
        w_busy_next      = (w_state_next == S_COMPARE) || (w_state_next == S_SHOW);
        w_done_next      = (w_state_next == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cursor_pos <= 4'd0;
            cursor_en  <= 1'b1;
            face_up    <= 16'd0;
            matched    <= 16'd0;
            score      <= 4'd0;
            busy       <= 1'b0;
            game_done  <= 1'b0;
            r_first    <= 4'd0;
            r_second   <= 4'd0;
            r_timer    <= '0;
`ifdef MISS_COUNT_EN
            misses     <= 8'd0;
`endif
        end else begin
            cursor_en <= w_cursor_en_next;
            busy      <= w_busy_next;
            game_done <= w_done_next;
            case (r_state)
                S_PICK1, S_PICK2: begin
                    if (btn_up) begin
                        cursor_pos[3:2] <= cursor_pos[3:2] - 2'd1;
                    end else if (btn_down) begin
                        cursor_pos[3:2] <= cursor_pos[3:2] + 2'd1;
                    end else if (btn_left) begin
                        cursor_pos[1:0] <= cursor_pos[1:0] - 2'd1;
                    end else if (btn_right) begin
                        cursor_pos[1:0] <= cursor_pos[1:0] + 2'd1;
                    end else if (w_pick_ok) begin
                        face_up[cursor_pos] <= 1'b1;
                        if (r_state == S_PICK1) begin
                            r_first <= cursor_pos;
                        end else begin
                            r_second <= cursor_pos;
                        end
                    end
                end
                S_COMPARE: begin
                    if (w_match) begin
                        matched[r_first]  <= 1'b1;
                        matched[r_second] <= 1'b1;
                        score             <= score + 4'd1;
                    end else begin
                        r_timer <= TIMER_LOAD;
`ifdef MISS_COUNT_EN
                        if (misses != 8'hFF) misses <= misses + 8'd1;
`endif
                    end
                end
                S_SHOW: begin
                    if (w_timer_zero) begin
                        face_up[r_first]  <= 1'b0;
                        face_up[r_second] <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_sel) begin
                        face_up    <= 16'd0;
                        matched    <= 16'd0;
                        score      <= 4'd0;
                        cursor_pos <= 4'd0;
`ifdef MISS_COUNT_EN
                        misses     <= 8'd0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_card_select_ctrl.sv
// Self-checking bench for card_select_ctrl with an abstract game model (HOLD_CYCLES=4).
module tb_card_select_ctrl;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
    logic [47:0] layout = 48'd0;
    logic [3:0]  cursor_pos;
    logic        cursor_en;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic [3:0]  score;
    logic        busy;
    logic        game_done;
`ifdef MISS_COUNT_EN
    logic [7:0]  misses;
`endif

    card_select_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel), .layout(layout),
        .cursor_pos(cursor_pos), .cursor_en(cursor_en), .face_up(face_up),
        .matched(matched), .score(score), .busy(busy), .game_done(game_done)
`ifdef MISS_COUNT_EN
        , .misses(misses)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam int M_PICK = 0, M_CMP = 1, M_SHOW = 2, M_DONE = 3;
    int        m_mode, m_row, m_col, m_sc, m_npick, m_first, m_second;
    int        m_cyc, m_clear_edge, m_miss;
    bit [15:0] m_face, m_mat;
    bit        chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic int sym(input int p);
        return int'((layout >> (3 * p)) & 48'd7);
    endfunction

    task automatic model_reset();
        m_mode = M_PICK; m_row = 0; m_col = 0; m_sc = 0; m_npick = 0;
        m_face = '0; m_mat = '0; m_miss = 0;
    endtask

    // Game rules applied once per clock edge, from the inputs seen at that edge.
    task automatic model_step();
        bit any_dir, sel_ok;
        int p;
        m_cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        any_dir = btn_up | btn_down | btn_left | btn_right;
        sel_ok  = btn_sel & ~any_dir;
        p = m_row * 4 + m_col;
        case (m_mode)
            M_PICK: begin
                if (btn_up)         m_row = (m_row + 3) % 4;
                else if (btn_down)  m_row = (m_row + 1) % 4;
                else if (btn_left)  m_col = (m_col + 3) % 4;
                else if (btn_right) m_col = (m_col + 1) % 4;
                else if (sel_ok && !m_face[p]) begin
                    m_face[p] = 1'b1;
                    if (m_npick == 0) begin
                        m_first = p; m_npick = 1;
                    end else begin
                        m_second = p; m_npick = 0; m_mode = M_CMP;
                    end
                end
            end
            M_CMP: begin
                if (sym(m_first) == sym(m_second)) begin
                    m_mat[m_first] = 1'b1; m_mat[m_second] = 1'b1;
                    m_sc++;
                    m_mode = (m_sc == 8) ? M_DONE : M_PICK;
                end else begin
                    m_clear_edge = m_cyc + HOLD;
                    m_mode = M_SHOW;
                    if (m_miss < 255) m_miss++;
                end
            end
            M_SHOW: begin
                if (m_cyc == m_clear_edge) begin
                    m_face[m_first] = 1'b0; m_face[m_second] = 1'b0;
                    m_mode = M_PICK;
                end
            end
            default: begin
                if (sel_ok) begin
                    m_face = '0; m_mat = '0; m_sc = 0; m_row = 0; m_col = 0; m_miss = 0;
                    m_mode = M_PICK;
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cursor_pos", cursor_pos, m_row * 4 + m_col);
            chk("cursor_en", cursor_en, m_mode == M_PICK);
            chk("face_up", face_up, m_face);
            chk("matched", matched, m_mat);
            chk("score", score, m_sc);
            chk("busy", busy, (m_mode == M_CMP) || (m_mode == M_SHOW));
            chk("game_done", game_done, m_mode == M_DONE);
`ifdef MISS_COUNT_EN
            chk("misses", misses, m_miss);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
    endtask

    task automatic press(input bit u, input bit d, input bit l, input bit r, input bit s);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
        tick();
    endtask

    task automatic goto_card(input int p);
        while (m_row != p / 4) press(0, 1, 0, 0, 0);
        while (m_col != p % 4) press(0, 0, 0, 1, 0);
    endtask

    task automatic set_pairs_layout(input bit shuffle);
        int s [16];
        int j, t;
        for (int i = 0; i < 16; i++) s[i] = (i / 2 + 5) % 8;
        if (shuffle) begin
            for (int i = 15; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = s[i]; s[i] = s[j]; s[j] = t;
            end
        end
        for (int i = 0; i < 16; i++) layout[3*i +: 3] = 3'(s[i]);
    endtask

    task automatic one_mismatch();
        goto_card(0);
        press(0, 0, 0, 0, 1);
        goto_card(2);
        press(0, 0, 0, 0, 1);
        repeat (HOLD + 2) tick();
    endtask

    initial begin
        model_reset();
        m_cyc = 0;
        set_pairs_layout(1'b0);
        reset = 1;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 0;
        chk("rst_pos", cursor_pos, 4'd0);
        chk("rst_en", cursor_en, 1'b1);

        // Cursor wrap and priority
        press(0, 0, 1, 0, 0); chk("left_wrap", cursor_pos, 4'd3);
        press(1, 0, 0, 0, 0); chk("up_wrap", cursor_pos, 4'd15);
        press(0, 1, 0, 0, 0); chk("down_wrap", cursor_pos, 4'd3);
        press(1, 0, 0, 1, 0); chk("up_over_right", cursor_pos, 4'd15);
        press(0, 0, 0, 1, 1); chk("move_beats_sel", face_up, 16'h0000);

        // Matching pair at cards 0 and 1
        goto_card(0);
        press(0, 0, 0, 0, 1); chk("first_face", face_up, 16'h0001);
        press(0, 0, 0, 1, 0);
        press(0, 0, 0, 0, 1);
        chk("pair_face", face_up, 16'h0003);
        chk("pair_busy", busy, 1'b1);
        chk("pair_matched_early", matched, 16'h0000);
        tick();
        chk("pair_matched", matched, 16'h0003);
        chk("pair_score", score, 4'd1);
        chk("pair_busy_end", busy, 1'b0);

        // Matched card and repeated select are ignored
        press(0, 0, 0, 0, 1); chk("sel_matched", face_up, 16'h0003);
        goto_card(2);
        press(0, 0, 0, 0, 1);
        press(0, 0, 0, 0, 1);
        chk("sel_twice", face_up, 16'h0007);
        chk("sel_twice_busy", busy, 1'b0);
        press(0, 0, 0, 1, 0);
        press(0, 0, 0, 0, 1);
        tick();
        chk("score2", score, 4'd2);

        // Finish the game
        for (int k = 2; k < 8; k++) begin
            goto_card(2 * k);
            press(0, 0, 0, 0, 1);
            goto_card(2 * k + 1);
            press(0, 0, 0, 0, 1);
            tick();
        end
        tick();
        chk("done_score", score, 4'd8);
        chk("done_flag", game_done, 1'b1);
        chk("done_cursor_en", cursor_en, 1'b0);
        chk("done_matched", matched, 16'hFFFF);
        press(0, 1, 0, 0, 0); chk("done_no_move", cursor_pos, 4'd15);
        press(0, 0, 0, 0, 1);
        chk("restart_face", face_up, 16'h0000);
        chk("restart_matched", matched, 16'h0000);
        chk("restart_score", score, 4'd0);
        chk("restart_pos", cursor_pos, 4'd0);
        chk("restart_done", game_done, 1'b0);

        // Mismatch hold: card0=2, card2=6
        layout[2:0] = 3'd2;
        layout[8:6] = 3'd6;
        press(0, 0, 0, 0, 1);
        press(0, 0, 0, 1, 0);
        press(0, 0, 0, 1, 0);
        press(0, 0, 0, 0, 1);
        chk("miss_face", face_up, 16'h0005);
        chk("miss_busy", busy, 1'b1);
        for (int i = 0; i < HOLD; i++) begin
            press(i == 0, 0, i == 1, 0, i >= 2);
            chk("show_face_hold", face_up, 16'h0005);
            chk("show_pos_hold", cursor_pos, 4'd2);
            chk("show_cursor_off", cursor_en, 1'b0);
        end
        tick();
        chk("show_cleared", face_up, 16'h0000);
        chk("show_cursor_on", cursor_en, 1'b1);

        // Reset in the middle of SHOW
        goto_card(0);
        press(0, 0, 0, 0, 1);
        goto_card(2);
        press(0, 0, 0, 0, 1);
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_show_face", face_up, 16'h0000);
        chk("rst_show_busy", busy, 1'b0);
        chk("rst_show_en", cursor_en, 1'b1);
        chk("rst_show_pos", cursor_pos, 4'd0);

        repeat (3) one_mismatch();
`ifdef MISS_COUNT_EN
        chk("misses3", misses, 8'd3);
`endif

        // Randomized play
        for (int n = 0; n < 4000; n++) begin
            int r;
            if ($urandom_range(399, 0) == 0) begin
                reset = 1;
                set_pairs_layout(1'b1);
                tick();
                reset = 0;
            end else begin
                r = int'($urandom_range(15, 0));
                case (r)
                    0: press(1, 0, 0, 0, 0);
                    1: press(0, 1, 0, 0, 0);
                    2: press(0, 0, 1, 0, 0);
                    3: press(0, 0, 0, 1, 0);
                    4, 5, 6, 7: press(0, 0, 0, 0, 1);
                    8: press(1, 0, 0, 0, 1);
                    9: press(0, 1, 1, 0, 0);
                    10: press(0, 0, 1, 1, 0);
                    default: tick();
                endcase
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/card_select_ctrl.md
Name: card_select_ctrl

Overview:
- Game controller for the 4x4 memory-card board; sits directly upstream of the per-card sprite renderer.
- Converts debounced button pulses into the cursor position (pos, enable) that the renderer draws.
- Tracks which cards are face-up or matched, compares each selected pair, holds a mismatched pair visible for a fixed time, and counts found pairs.

Parameters:
- HOLD_CYCLES, 25_000_000: cycles a mismatched pair stays face-up (1 s at 25 MHz); minimum 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- btn_up  in  1  one-cycle pulse, move cursor up one row
- btn_down  in  1  one-cycle pulse, move cursor down one row
- btn_left  in  1  one-cycle pulse, move cursor left one column
- btn_right  in  1  one-cycle pulse, move cursor right one column
- btn_sel  in  1  one-cycle pulse, flip card under cursor / restart when done
- layout  in  48  symbol of card i at [3i+2:3i]; must be stable while busy
- cursor_pos  out  4  card index {row[1:0],col[1:0]}, drives renderer pos
- cursor_en  out  1  cursor visible, drives renderer enable
- face_up  out  16  bit i = card i shown face-up (includes matched cards)
- matched  out  16  bit i = card i permanently matched
- score  out  4  pairs found, 0..8
- busy  out  1  compare/hold in progress, input ignored
- game_done  out  1  all 8 pairs found

Behaviour:
- All outputs registered. Reset values: cursor_pos=0, cursor_en=1, face_up=0, matched=0, score=0, busy=0, game_done=0, state=PICK1.
- States: PICK1, PICK2, COMPARE, SHOW, DONE.
- Cursor moves are accepted only in PICK1/PICK2.
  - up/down change row = pos[3:2] by -1/+1 mod 4; left/right change col = pos[1:0] by -1/+1 mod 4, so both axes wrap.
  - One move per cycle. Priority up > down > left > right.
  - cursor_pos updates the cycle after the pulse.
- btn_sel in the same cycle as any direction pulse is ignored; the move wins.
- PICK1, btn_sel:
  - Card at cursor_pos already face_up: ignored.
  - Otherwise set face_up[pos], latch first=pos, go to PICK2 next cycle.
- PICK2, btn_sel:
  - Card at cursor_pos already face_up (including first): ignored.
  - Otherwise set face_up[pos], latch second=pos, go to COMPARE.
- COMPARE, 1 cycle, busy=1, cursor_en=0:
  - Symbols equal: set matched[first], matched[second], score+1. Go to DONE if the new score is 8, else PICK1.
  - Symbols differ: load timer=HOLD_CYCLES-1, go to SHOW.
- SHOW, busy=1, cursor_en=0, all buttons ignored:
  - Timer decrements each cycle.
  - When timer=0: clear face_up[first], face_up[second], go to PICK1.
  - Mismatch total: face_up cleared exactly HOLD_CYCLES+1 cycles after COMPARE entry.
- DONE: game_done=1, cursor_en=0, busy=0, direction buttons ignored.
  - btn_sel clears face_up, matched and score, sets cursor_pos=0 and game_done=0, goes to PICK1.
- Latency, second btn_sel at cycle n:
  - face_up at n+1.
  - matched/score at n+2.
  - On mismatch, SHOW entered at n+2.
- Reset mid-SHOW or mid-COMPARE: immediate return to reset values. No pending clear or score update survives.
- cursor_pos holds its value through COMPARE/SHOW.
- score never exceeds 8; 4-bit, no wrap.
- Timer is wide enough for HOLD_CYCLES-1.

Optional Feature:
- Macro MISS_COUNT_EN.
- Defined: extra output port misses [7:0].
  - Increments on every COMPARE mismatch, saturates at 255.
  - Cleared by reset and by the DONE restart.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan (HOLD_CYCLES=4):
- Reset, then btn_left -> cursor_pos=3. btn_up -> 15. btn_down -> 3. btn_up+btn_right same cycle -> 15 (up only).
- Layout card0=card1=sym 5. sel@0, right, sel@1 -> face_up=0x0003, matched=0x0003, score=1 two cycles after the second sel, busy high 1 cycle.
- Layout card0=2, card2=6. sel@0, sel@2 -> busy=1, face_up=0x0005 held; face_up=0x0000 and cursor_en=1 exactly 5 cycles after COMPARE entry; buttons during SHOW cause no change.
- sel twice on the same card, and sel on a matched card -> no state change, face_up unchanged.
- Find all 8 pairs -> score=8, game_done=1, cursor_en=0. btn_sel -> all cleared, PICK1, cursor_pos=0.
- Assert reset during SHOW -> next cycle all outputs at reset values. With MISS_COUNT_EN: 3 mismatches -> misses=3.
